// File: rtl/y86_mem_pkg.sv
// y86_mem_pkg: shared state encoding, port ids and data-memory geometry defaults.
package y86_mem_pkg;
    typedef enum logic [2:0] {IDLE, ACCESS, WAIT, RESP, ERR} state_t;
    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;
    localparam int AW_DEF = 10;
    localparam int ADDR_LIMIT_DEF = 1024;
endpackage

// File: rtl/y86_mem_arb_pick.sv
// y86_mem_arb_pick: DM-priority winner select; MEM_ARB_AGE_EN lets a starved IF win.
module y86_mem_arb_pick import y86_mem_pkg::*; #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic idle,
    input  logic if_req,
    input  logic dm_req,
    output logic win,
    output logic gnt
);
`ifdef MEM_ARB_AGE_EN
    localparam int CW = $clog2(MAX_WAIT + 1);
    logic [CW-1:0] age;
    logic aged;
    assign aged = age == CW'(MAX_WAIT);
    assign win = (dm_req && !(aged && if_req)) ? PORT_DM : PORT_IF;
    // saturating count of IF denials, cleared whenever IF wins
    always_ff @(posedge clk or posedge rst)
        if (rst) age <= '0;
        else if (idle && if_req) age <= (win == PORT_IF) ? '0 : aged ? age : age + 1'b1;
`else
    logic unused;
    assign unused = clk ^ rst ^ (MAX_WAIT > 0);
    assign win = dm_req ? PORT_DM : PORT_IF;
`endif
    assign gnt = idle && (if_req || dm_req);
endmodule

// File: rtl/y86_mem_arbiter.sv
// y86_mem_arbiter: one-access-at-a-time IF/DM arbiter in front of the data RAM.
// Define MEM_ARB_AGE_EN to enable fetch-starvation aging.
module y86_mem_arbiter import y86_mem_pkg::*; #(
    parameter int DW = 64,
    parameter int AW = AW_DEF,
    parameter int ADDR_LIMIT = ADDR_LIMIT_DEF,
    parameter int MEM_LAT = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [63:0]   if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    output logic          if_err,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [63:0]   dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    state_t state;
    logic port, we, win, pick_gnt, bad, go_resp;
    logic [1:0] cnt;
    logic [63:0] sel_addr;
    logic [DW-1:0] wdata, if_hold, dm_hold, resp_data;

    y86_mem_arb_pick #(.MAX_WAIT(MAX_WAIT)) u_pick (
        .clk(clk), .rst(rst), .idle(state == IDLE && !rst), .if_req(if_req), .dm_req(dm_req),
        .win(win), .gnt(pick_gnt)
    );

    // rdata follows the RAM live during RESP and otherwise shows the held value
    always_comb begin
        sel_addr = win == PORT_DM ? dm_addr : if_addr;
        bad = sel_addr >= 64'(ADDR_LIMIT);
        go_resp = (state == ACCESS && MEM_LAT == 1) || (state == WAIT && cnt == 2'd1);
        resp_data = we ? wdata : mem_rdata;
        if_gnt = pick_gnt && win == PORT_IF;
        dm_gnt = pick_gnt && win == PORT_DM;
        if_rdata = (state == RESP && port == PORT_IF) ? resp_data : if_hold;
        dm_rdata = (state == RESP && port == PORT_DM) ? resp_data : dm_hold;
    end

    assign mem_wdata = wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            port <= PORT_IF;
            we <= 1'b0;
            cnt <= '0;
            wdata <= '0;
            if_hold <= '0;
            dm_hold <= '0;
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            if_err <= 1'b0;
            dm_err <= 1'b0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            case (state)
                IDLE: if (pick_gnt) begin
                    port <= win;
                    we <= win == PORT_DM && dm_we;
                    wdata <= win == PORT_DM ? dm_wdata : '0;
                    mem_addr <= sel_addr[AW-1:0];
                    if (bad) begin
                        state <= ERR;
                        if (win == PORT_IF) begin
                            if_rvalid <= 1'b1;
                            if_err <= 1'b1;
                            if_hold <= '0;
                        end else begin
                            dm_rvalid <= 1'b1;
                            dm_err <= 1'b1;
                            dm_hold <= '0;
                        end
                    end else begin
                        state <= ACCESS;
                        mem_en <= 1'b1;
                        mem_we <= win == PORT_DM && dm_we;
                    end
                end
                ACCESS: begin
                    cnt <= 2'(MEM_LAT - 1);
                    state <= MEM_LAT == 1 ? RESP : WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == 2'd1) state <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                    if (port == PORT_IF) if_hold <= resp_data;
                    else dm_hold <= resp_data;
                end
                default: state <= IDLE;
            endcase
            if (go_resp) begin
                if (port == PORT_IF) begin
                    if_rvalid <= 1'b1;
                    if_err <= 1'b0;
                end else begin
                    dm_rvalid <= 1'b1;
                    dm_err <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_y86_mem_arbiter.sv
// tb_y86_mem_arbiter: scoreboard bench; u_dut runs MEM_LAT=1, u_dut3 runs MEM_LAT=3.
module tb_y86_mem_arbiter;
    typedef struct packed { logic [63:0] data; logic err; } exp_t;
    logic clk = 1'b0, rst = 1'b1;
    int cyc = 0;
    int n_cmp = 0, n_bad = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic if_req = 0, if_gnt, if_rvalid, if_err;
    logic [63:0] if_addr = 0, if_rdata;
    logic dm_req = 0, dm_we = 0, dm_gnt, dm_rvalid, dm_err;
    logic [63:0] dm_addr = 0, dm_wdata = 0, dm_rdata;
    logic mem_en, mem_we;
    logic [9:0] mem_addr;
    logic [63:0] mem_wdata, mem_rdata, ram_q;

    logic b_if_req = 0, b_if_gnt, b_if_rvalid, b_if_err;
    logic [63:0] b_if_addr = 0, b_if_rdata;
    logic b_dm_req = 0, b_dm_we = 0, b_dm_gnt, b_dm_rvalid, b_dm_err;
    logic [63:0] b_dm_addr = 0, b_dm_wdata = 0, b_dm_rdata;
    logic b_mem_en, b_mem_we;
    logic [9:0] b_mem_addr;
    logic [63:0] b_mem_wdata, b_mem_rdata;

    logic [63:0] ram [1024];
    logic [63:0] ram3 [1024];
    logic [63:0] pipe3 [3];

    function automatic logic [63:0] init_val(input int i);
        return 64'h0123_4567_0000_0000 | 64'(i * 7 + 1);
    endfunction

    initial for (int i = 0; i < 1024; i++) begin
        ram[i] = init_val(i);
        ram3[i] = init_val(i);
    end

    // RAM models: one-cycle and three-cycle read latency
    always @(posedge clk) begin
        if (mem_en) begin
            ram_q <= ram[mem_addr];
            if (mem_we) ram[mem_addr] = mem_wdata;
        end
        pipe3[0] <= b_mem_en ? ram3[b_mem_addr] : 64'hBAD0_BAD0_BAD0_BAD0;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
        if (b_mem_en && b_mem_we) ram3[b_mem_addr] = b_mem_wdata;
    end
    assign mem_rdata = ram_q;
    assign b_mem_rdata = pipe3[2];

    y86_mem_arbiter #(.MEM_LAT(1)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_err(if_err),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
        .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_err(dm_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    y86_mem_arbiter #(.MEM_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid),
        .if_rdata(b_if_rdata), .if_err(b_if_err),
        .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
        .dm_gnt(b_dm_gnt), .dm_rvalid(b_dm_rvalid), .dm_rdata(b_dm_rdata), .dm_err(b_dm_err),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata)
    );

    task automatic run_dm(input logic w, input logic [63:0] a, input logic [63:0] d,
                          output int t0, output int tg, output int te, output int tr,
                          output logic [63:0] rd, output logic er, output logic ew);
        @(negedge clk);
        dm_req = 1'b1; dm_we = w; dm_addr = a; dm_wdata = d;
        t0 = cyc; tg = -1; te = -1; tr = -1; rd = '0; er = 1'b0; ew = 1'b0;
        while (tr < 0 && cyc - t0 < 20) begin
            #1;
            if (dm_gnt && tg < 0) tg = cyc;
            if (mem_en && te < 0) begin te = cyc; ew = mem_we; end
            if (dm_rvalid) begin tr = cyc; rd = dm_rdata; er = dm_err; end
            @(negedge clk);
            if (tg >= 0) dm_req = 1'b0;
        end
        dm_req = 1'b0;
    endtask

    task automatic run_if3(input logic [63:0] a, output int t0, output int tg, output int te,
                           output int tr, output logic [63:0] rd, output logic er);
        @(negedge clk);
        b_if_req = 1'b1; b_if_addr = a;
        t0 = cyc; tg = -1; te = -1; tr = -1; rd = '0; er = 1'b0;
        while (tr < 0 && cyc - t0 < 20) begin
            #1;
            if (b_if_gnt && tg < 0) tg = cyc;
            if (b_mem_en && te < 0) te = cyc;
            if (b_if_rvalid) begin tr = cyc; rd = b_if_rdata; er = b_if_err; end
            @(negedge clk);
            if (tg >= 0) b_if_req = 1'b0;
        end
        b_if_req = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        dm_req = 1'b1;
        b_if_req = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid, if_err, dm_err, mem_en, mem_we, mem_addr,
             mem_wdata, if_rdata, dm_rdata} !== '0) begin
            n_bad++;
            $display("FAIL reset_a: gnt/rvalid/err/mem=%b%b%b%b%b%b%b%b addr=%h rdata=%h/%h expected all 0",
                     if_gnt, dm_gnt, if_rvalid, dm_rvalid, if_err, dm_err, mem_en, mem_we, mem_addr,
                     if_rdata, dm_rdata);
        end
        n_cmp++;
        if ({b_if_gnt, b_dm_gnt, b_if_rvalid, b_dm_rvalid, b_mem_en, b_mem_addr} !== '0) begin
            n_bad++;
            $display("FAIL reset_b: gnt=%b%b rvalid=%b%b mem_en=%b addr=%h expected all 0",
                     b_if_gnt, b_dm_gnt, b_if_rvalid, b_dm_rvalid, b_mem_en, b_mem_addr);
        end
        dm_req = 1'b0;
        b_if_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_dm_write_read;
        int t0, tg, te, tr;
        logic [63:0] rd;
        logic er, ew;
        exp_t e;
        exp_q.push_back({64'hDEAD, 1'b0});
        run_dm(1'b1, 64'd5, 64'hDEAD, t0, tg, te, tr, rd, er, ew);
        e = exp_q.pop_front();
        n_cmp++;
        if (tg !== t0) begin n_bad++; $display("FAIL wr_gnt: cycle %0d expected %0d", tg, t0); end
        n_cmp++;
        if (te !== tg + 1 || ew !== 1'b1) begin
            n_bad++; $display("FAIL wr_mem_en: cycle %0d we=%b expected %0d we=1", te, ew, tg + 1);
        end
        n_cmp++;
        if (tr !== tg + 2 || {rd, er} !== e) begin
            n_bad++;
            $display("FAIL wr_resp: cycle %0d data=%h err=%b expected cycle %0d data=%h err=%b",
                     tr, rd, er, tg + 2, e.data, e.err);
        end
        exp_q.push_back({64'hDEAD, 1'b0});
        run_dm(1'b0, 64'd5, 64'hFFFF_0000_FFFF_0000, t0, tg, te, tr, rd, er, ew);
        e = exp_q.pop_front();
        n_cmp++;
        if (tr !== tg + 2 || ew !== 1'b0 || {rd, er} !== e) begin
            n_bad++;
            $display("FAIL rd_resp: cycle %0d we=%b data=%h err=%b expected cycle %0d we=0 data=%h err=%b",
                     tr, ew, rd, er, tg + 2, e.data, e.err);
        end
    endtask

    task automatic test_contention;
        int t0, tdg, tig, nresp;
        exp_t e, got;
        exp_q.push_back({64'hDEAD, 1'b0});
        exp_q.push_back({init_val(9), 1'b0});
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'd5; if_req = 1'b1; if_addr = 64'd9;
        t0 = cyc; tdg = -1; tig = -1; nresp = 0;
        while (nresp < 2 && cyc - t0 < 30) begin
            #1;
            if (dm_gnt && tdg < 0) tdg = cyc;
            if (if_gnt && tig < 0) tig = cyc;
            if (dm_rvalid || if_rvalid) begin
                e = exp_q.pop_front();
                nresp++;
                got = dm_rvalid ? {dm_rdata, dm_err} : {if_rdata, if_err};
                n_cmp++;
                if (got !== e || (nresp == 1) !== dm_rvalid) begin
                    n_bad++;
                    $display("FAIL cont_resp%0d: dm_rvalid=%b data=%h err=%b expected data=%h err=%b",
                             nresp, dm_rvalid, got.data, got.err, e.data, e.err);
                end
            end
            @(negedge clk);
            if (tdg >= 0) dm_req = 1'b0;
            if (tig >= 0) if_req = 1'b0;
        end
        dm_req = 1'b0;
        if_req = 1'b0;
        n_cmp++;
        if (tdg !== t0) begin n_bad++; $display("FAIL cont_dm_gnt: cycle %0d expected %0d", tdg, t0); end
        n_cmp++;
        if (tig !== tdg + 3) begin n_bad++; $display("FAIL cont_if_gnt: cycle %0d expected %0d", tig, tdg + 3); end
        n_cmp++;
        if (nresp !== 2) begin n_bad++; $display("FAIL cont_count: %0d responses expected 2", nresp); end
        exp_q.delete();
    endtask

    task automatic test_addr_err;
        int t0, tg, te, tr;
        logic [63:0] rd;
        logic er, ew;
        exp_t e;
        exp_q.push_back({64'd0, 1'b1});
        run_dm(1'b0, 64'd1024, 64'd0, t0, tg, te, tr, rd, er, ew);
        e = exp_q.pop_front();
        n_cmp++;
        if (tr !== tg + 1 || te !== -1 || {rd, er} !== e) begin
            n_bad++;
            $display("FAIL err_1024: rv cycle %0d mem_en cycle %0d data=%h err=%b expected rv %0d no mem_en data=0 err=1",
                     tr, te, rd, er, tg + 1);
        end
        exp_q.push_back({64'd0, 1'b1});
        run_dm(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, t0, tg, te, tr, rd, er, ew);
        e = exp_q.pop_front();
        n_cmp++;
        if (tr !== tg + 1 || te !== -1 || {rd, er} !== e) begin
            n_bad++;
            $display("FAIL err_max: rv cycle %0d mem_en cycle %0d data=%h err=%b expected rv %0d no mem_en data=0 err=1",
                     tr, te, rd, er, tg + 1);
        end
        exp_q.push_back({init_val(1023), 1'b0});
        run_dm(1'b0, 64'd1023, 64'd0, t0, tg, te, tr, rd, er, ew);
        e = exp_q.pop_front();
        n_cmp++;
        if (tr !== tg + 2 || te !== tg + 1 || {rd, er} !== e) begin
            n_bad++;
            $display("FAIL ok_1023: rv cycle %0d mem_en %0d data=%h err=%b expected rv %0d mem_en %0d data=%h err=0",
                     tr, te, rd, er, tg + 2, tg + 1, e.data);
        end
    endtask

    task automatic test_mem_lat3;
        int t0, tg, te, tr;
        logic [63:0] rd;
        logic er;
        exp_t e;
        exp_q.push_back({init_val(7), 1'b0});
        run_if3(64'd7, t0, tg, te, tr, rd, er);
        e = exp_q.pop_front();
        n_cmp++;
        if (te !== tg + 1) begin n_bad++; $display("FAIL lat3_mem_en: cycle %0d expected %0d", te, tg + 1); end
        n_cmp++;
        if (tr !== tg + 4 || {rd, er} !== e) begin
            n_bad++;
            $display("FAIL lat3_resp: cycle %0d data=%h err=%b expected cycle %0d data=%h err=0",
                     tr, rd, er, tg + 4, e.data);
        end
    endtask

    task automatic test_reset_mid;
        int t0, tg, te, tr, nrv;
        logic [63:0] rd;
        logic er;
        exp_t e;
        @(negedge clk);
        b_if_req = 1'b1; b_if_addr = 64'd11;
        t0 = cyc; tg = -1;
        while (tg < 0 && cyc - t0 < 10) begin
            #1;
            if (b_if_gnt) tg = cyc;
            @(negedge clk);
        end
        b_if_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({b_if_gnt, b_dm_gnt, b_if_rvalid, b_dm_rvalid, b_if_err, b_dm_err, b_mem_en, b_mem_we,
             b_mem_addr, b_mem_wdata, b_if_rdata, b_dm_rdata} !== '0) begin
            n_bad++;
            $display("FAIL midrst_outputs: rvalid=%b mem_en=%b addr=%h if_rdata=%h expected all 0",
                     b_if_rvalid, b_mem_en, b_mem_addr, b_if_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        nrv = 0;
        repeat (6) begin
            #1;
            if (b_if_rvalid || b_dm_rvalid) nrv++;
            @(negedge clk);
        end
        n_cmp++;
        if (nrv !== 0) begin n_bad++; $display("FAIL midrst_no_rvalid: %0d pulses expected 0", nrv); end
        exp_q.push_back({init_val(13), 1'b0});
        run_if3(64'd13, t0, tg, te, tr, rd, er);
        e = exp_q.pop_front();
        n_cmp++;
        if (tg !== t0 || tr !== tg + 4 || {rd, er} !== e) begin
            n_bad++;
            $display("FAIL midrst_fresh: gnt %0d rv %0d data=%h expected gnt %0d rv %0d data=%h",
                     tg, tr, rd, t0, t0 + 4, e.data);
        end
    endtask

    task automatic test_aging;
        int n_dm, n_if, dm_before, dm_after, t0;
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'd5; if_req = 1'b1; if_addr = 64'd3;
        n_dm = 0; n_if = 0; dm_before = -1; dm_after = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (if_gnt) begin n_if++; if (dm_before < 0) dm_before = n_dm; end
            if (dm_gnt) begin n_dm++; if (n_if > 0) dm_after++; end
            @(negedge clk);
            if (n_if > 0) if_req = 1'b0;
        end
`ifdef MEM_ARB_AGE_EN
        n_cmp++;
        if (dm_before !== 4) begin n_bad++; $display("FAIL age_denials: %0d DM grants before IF expected 4", dm_before); end
        n_cmp++;
        if (n_if !== 1 || dm_after < 1) begin
            n_bad++; $display("FAIL age_resume: IF grants %0d DM after %0d expected 1 and >=1", n_if, dm_after);
        end
`else
        n_cmp++;
        if (n_if !== 0 || n_dm < 8) begin
            n_bad++; $display("FAIL strict_prio: IF grants %0d DM grants %0d expected 0 and >=8", n_if, n_dm);
        end
        dm_req = 1'b0;
        t0 = cyc;
        while (n_if == 0 && cyc - t0 < 10) begin
            #1;
            if (if_gnt) n_if++;
            @(negedge clk);
        end
        n_cmp++;
        if (n_if !== 1) begin n_bad++; $display("FAIL strict_if_after: IF grants %0d expected 1", n_if); end
`endif
        dm_req = 1'b0;
        if_req = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_dm_write_read();
        test_contention();
        test_addr_err();
        test_mem_lat3();
        test_reset_mid();
        test_aging();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/y86_mem_arbiter.md
Name: y86_mem_arbiter

Overview:
- Shares the single 1024 x 64-bit data memory between two requesters: instruction fetch (IF port) and the memory stage (DM port, which handles rmmovq, mrmovq, call, ret, pushq and popq).
- Runs one access at a time through a request/grant/response handshake.
- Range-checks every address and reports mem_err per access.
- Sits between the fetch/memory stages and the RAM macro; the RAM has a fixed read latency.

Parameters:
- DW, 64, data width.
- AW, 10, RAM word-address width.
- ADDR_LIMIT, 1024, first illegal word address.
- MEM_LAT, 1, RAM read latency in cycles (1..4).
- MAX_WAIT, 4, IF starvation threshold (aging feature only).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- if_req  in  1  fetch read request
- if_addr  in  64  fetch word address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch response pulse
- if_rdata  out  64  fetch read data
- if_err  out  1  fetch address error, valid with if_rvalid
- dm_req  in  1  data request
- dm_we  in  1  1 = write (rmmovq, call, pushq), 0 = read
- dm_addr  in  64  data word address (valE, or valA for ret/popq)
- dm_wdata  in  64  write data (valA or valP)
- dm_gnt  out  1  data request accepted
- dm_rvalid  out  1  data response pulse
- dm_rdata  out  64  read data, or echoed write data for writes (valM)
- dm_err  out  1  address error, valid with dm_rvalid
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM word address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, valid MEM_LAT cycles after mem_en

Behaviour:
- Reset (async, rst=1):
  - state = IDLE.
  - All outputs are 0, including gnt, rvalid, err, rdata, mem_* and the aging counter.
  - Reset mid-access discards the access and no rvalid is issued. A write already strobed into the RAM may have landed.
- FSM states: IDLE, ACCESS, WAIT, RESP, ERR.
- IDLE:
  - If any req is present, select a winner. DM has fixed priority over IF.
  - Assert the winner's gnt combinationally in that cycle. Capture port id, we, addr and wdata at the edge.
  - If captured addr >= ADDR_LIMIT (full 64-bit compare): go to ERR.
  - Otherwise: go to ACCESS.
- ACCESS (1 cycle):
  - Drive mem_en=1 with mem_we and mem_addr = addr[AW-1:0].
  - Load wait counter = MEM_LAT-1.
  - Go to WAIT, or to RESP if MEM_LAT == 1.
- WAIT: decrement the counter; go to RESP at 0.
- RESP (1 cycle):
  - Granted port's rvalid=1, err=0.
  - rdata = mem_rdata for reads, captured wdata for writes.
  - Go to IDLE.
- ERR (1 cycle):
  - rvalid=1, err=1, rdata=0.
  - No mem_en, so no RAM write occurs on error.
  - Go to IDLE.
- rdata and err hold their last value after the pulse. Consumers sample only on rvalid.
- Latency: gnt at cycle T. mem_en at T+1. rvalid at T+1+MEM_LAT (range OK) or at T+1 (error).
- No new grant before returning to IDLE. Peak throughput is one access per MEM_LAT+2 cycles.
- Requester rule: req stays high with stable address and data until gnt. The arbiter never grants while not in IDLE.
- Simultaneous if_req and dm_req: DM wins, and IF keeps waiting.
- Address boundaries: 1023 is legal; 1024 and 0xFFFF_FFFF_FFFF_FFFF are errors.

Optional Feature:
- Macro: MEM_ARB_AGE_EN.
- Enabled:
  - A saturating counter increments each IDLE cycle in which if_req is denied because DM won.
  - When it reaches MAX_WAIT, the next IDLE arbitration grants IF even if dm_req is high.
  - The counter clears on any IF grant.
- Disabled: strict DM priority, and no counter logic is synthesized.

Decomposition:
- Package y86_mem_pkg holds:
  - the state enum;
  - port-id constants PORT_IF and PORT_DM;
  - defaults for ADDR_LIMIT and AW, shared with the memory/RAM block.
- One natural sub-module, y86_mem_arb_pick:
  - combinational winner select plus the optional aging counter (under MEM_ARB_AGE_EN);
  - outputs winner id and grant.

Test Plan:
1. DM write then read, MEM_LAT=1: dm_we=1, addr=5, wdata=0xDEAD → dm_gnt at T, mem_en/mem_we at T+1, dm_rvalid at T+2 with rdata=0xDEAD. A subsequent read of addr 5 returns 0xDEAD.
2. Contention: if_req and dm_req both high in the same cycle → dm_gnt first. if_gnt comes at the first IDLE after the DM response. Both rvalids arrive with the correct data.
3. Address errors: dm_addr=1024 → dm_rvalid at T+1 with dm_err=1, rdata=0, and no mem_en. dm_addr=1023 → err=0 with a normal access.
4. MEM_LAT=3: IF read of addr 7 → mem_en at T+1, if_rvalid at T+4 with mem_rdata sampled correctly.
5. Reset mid-access: assert rst during WAIT → all outputs are 0 immediately, no rvalid, FSM in IDLE. A fresh request after deassert is granted normally.
6. With MEM_ARB_AGE_EN and MAX_WAIT=4: dm_req held high, if_req high → after 4 IF denials IF is granted once, then DM resumes. Without the macro, IF never wins while dm_req is high.
